// File: rtl/tim_ctrl.sv
// Up-counting timer: prescaler, shadowed auto-reload, update events, sticky IRQ flag, one-pulse mode.
// Optional PWM compare output is built when the TIM_PWM_EN macro is defined.
module tim_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] tim_psc,
  input  logic [CNT_W-1:0] tim_arr,
  input  logic [CNT_W-1:0] tim_ccr,
  input  logic             cen,
  input  logic             opm,
  input  logic             ug,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] psc_cnt,
  output logic             update,
  output logic             uif,
  output logic             busy,
  output logic             pwm_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] psc_sh;
  logic [CNT_W-1:0] arr_sh;
  logic             tick;
  logic             wrap;
  logic             nat_upd;
  logic             load_sh;

  assign tick    = (psc_cnt == psc_sh);
  assign wrap    = tick && (cnt == arr_sh);
  // A software update in the same cycle swallows the natural one, so uif stays untouched.
  assign nat_upd = (state == RUN) && wrap && !ug;
  assign load_sh = ug || nat_upd || ((state == IDLE) && cen);
  assign busy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      psc_cnt <= '0;
      psc_sh  <= '0;
      arr_sh  <= '0;
      update  <= 1'b0;
      uif     <= 1'b0;
    end else begin
      update <= 1'b0;

      if (load_sh) begin
        psc_sh <= tim_psc;
        arr_sh <= tim_arr;
      end

      if (nat_upd) begin
        uif <= 1'b1;
      end else if (irq_clr) begin
        uif <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt     <= '0;
          psc_cnt <= '0;
          if (cen) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (ug) begin
            cnt     <= '0;
            psc_cnt <= '0;
            update  <= 1'b1;
          end else if (wrap) begin
            cnt     <= '0;
            psc_cnt <= '0;
            update  <= 1'b1;
            if (opm) begin
              state <= DONE;
            end
          end else if (tick) begin
            psc_cnt <= '0;
            cnt     <= cnt + CNT_W'(1);
          end else begin
            psc_cnt <= psc_cnt + CNT_W'(1);
          end
          // Disable overrides both the counting and a one-pulse stop on the same edge.
          if (!cen) begin
            state   <= IDLE;
            cnt     <= '0;
            psc_cnt <= '0;
          end
        end

        DONE: begin
          cnt     <= '0;
          psc_cnt <= '0;
          if (!cen) begin
            state <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          psc_cnt <= '0;
        end
      endcase
    end
  end

`ifdef TIM_PWM_EN
  logic [CNT_W-1:0] ccr_sh;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ccr_sh <= '0;
    end else if (load_sh) begin
      ccr_sh <= tim_ccr;
    end
  end

  assign pwm_out = (state == RUN) && (cnt < ccr_sh);
`else
  logic unused_ccr;

  assign unused_ccr = ^tim_ccr;
  assign pwm_out    = 1'b0;
`endif

endmodule

// File: doc/tim_ctrl.md
# tim_ctrl

General-purpose up-counting timer controller for the RV32I microcontroller. It consumes the prescaler and auto-reload values written by the datapath (`TIM_PSC`, `TIM_ARR`) and latches them into shadow registers. It sequences the prescaler and main counter, generates update events and a sticky interrupt flag, and supports one-pulse mode. Optionally it also drives a PWM compare output.

## Interface

Parameters:
- `CNT_W`, default 16: width of prescaler, counter, ARR, PSC and CCR.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `tim_psc`  in  CNT_W  prescaler preload, from datapath `TIM_PSC`.
- `tim_arr`  in  CNT_W  auto-reload preload, from datapath `TIM_ARR`.
- `tim_ccr`  in  CNT_W  compare preload; used only with `TIM_PWM_EN`.
- `cen`  in  1  counter enable (level).
- `opm`  in  1  one-pulse mode (level); sampled at each update event.
- `ug`  in  1  software update-generate (1-cycle pulse).
- `irq_clr`  in  1  clears `uif` (1-cycle pulse).
- `cnt`  out  CNT_W  main counter value.
- `psc_cnt`  out  CNT_W  prescaler counter value.
- `update`  out  1  1-cycle update-event pulse.
- `uif`  out  1  sticky update interrupt flag.
- `busy`  out  1  high in state RUN.
- `pwm_out`  out  1  compare output.

## Operation

- State machine:
  - IDLE
    - `cnt` and `psc_cnt` are held at 0.
    - `cen`=1 → RUN. On the same edge, `psc_sh`←`tim_psc`, `arr_sh`←`tim_arr` and `ccr_sh`←`tim_ccr`.
  - RUN
    - Prescaler: if `psc_cnt`==`psc_sh`, then `psc_cnt`←0 and a tick is issued; otherwise `psc_cnt`+1.
    - On each tick: if `cnt`==`arr_sh`, then `cnt`←0 and an update event occurs; otherwise `cnt`+1.
    - `cen`=0 → IDLE. Counters clear on that edge; `uif` is retained.
  - DONE
    - Entered on an update event while `opm`=1.
    - Counters are held at 0.
    - `cen`=0 → IDLE.
- Update event (RUN only):
  - Shadows reload from their inputs.
  - `update` pulses.
  - `uif` is set.
- `ug` in RUN:
  - `cnt` and `psc_cnt` reset to 0 and the shadows reload.
  - `update` pulses; `uif` is not set.
  - `ug` takes priority over a same-cycle natural update.
- `ug` in IDLE or DONE: the shadows reload only.
- `uif`:
  - Set by an update event, cleared by `irq_clr`.
  - If set and clear occur in the same cycle, set wins.
- `busy` = (state==RUN).
- Period: (`psc_sh`+1)×(`arr_sh`+1) clocks.
  - `arr_sh`=0: an update occurs on every tick.
  - `psc_sh`=0: a tick occurs every clock.
- All arithmetic is unsigned CNT_W. No wrap can occur past `arr_sh`, because the compare is equality on a counter that starts at 0.
- Input changes to `tim_psc`, `tim_arr` and `tim_ccr` have no effect until the next shadow load.
- `cen` falling in the same cycle as an update event: go to IDLE; `uif` is still set.

## Timing

- All outputs are registered except `busy` and `pwm_out`, which decode from registers.
- Reset values:
  - `cnt`=0, `psc_cnt`=0, `update`=0, `uif`=0, `busy`=0, `pwm_out`=0.
  - State is IDLE; shadows are 0.
- `cen` sampled high in cycle N → RUN in cycle N+1, with `cnt`=0.
- The first `update` is high in cycle N+1+(`psc_sh`+1)×(`arr_sh`+1). In that same cycle `cnt`=0 and `uif`=1.
- `ug` sampled in cycle M → in cycle M+1, `cnt`=0, `psc_cnt`=0 and `update`=1.
- `irq_clr` in cycle M → `uif`=0 in cycle M+1, unless an update event occurs in cycle M.
- A reset assertion mid-run forces all reset values on the next edge.

## Configuration

- `TIM_PWM_EN` defined:
  - `ccr_sh` is implemented.
  - `pwm_out` = RUN && (`cnt` < `ccr_sh`).
  - `ccr_sh`=0 → always low; `ccr_sh` > `arr_sh` → always high while in RUN.
- `TIM_PWM_EN` undefined:
  - `ccr_sh` is not built and `tim_ccr` is ignored.
  - `pwm_out` is tied to 0.
  - The port list is unchanged.

## Test plan

- Reset: hold `reset`=0 for 3 cycles with `cen`=1 → all outputs 0, state IDLE. Release `reset` → first `update` 1+(`psc_sh`+1)×(`arr_sh`+1) cycles later.
- Basic period: PSC=0, ARR=3, `cen`=1 → `update` every 4 cycles; `cnt` sequence 1,2,3,0. With PSC=2, ARR=1 → `update` every 6 cycles.
- Shadow reload: PSC=0, ARR=3, running; write ARR=7 mid-period → current period stays 4 cycles; subsequent periods are 8 cycles.
- One-pulse / disable: `opm`=1, PSC=0, ARR=2 → exactly one `update`, after 3 cycles. State goes to DONE with `cnt` held at 0. Drop `cen` → IDLE; raise `cen` again → a new pulse follows.
- `uif` and `ug`:
  - `irq_clr` coincident with an update event → `uif` stays 1.
  - `ug` at `cnt`=2 with ARR=5 → `cnt`=0 and `update`=1 on the next cycle, with `uif` unchanged.
- PWM (`TIM_PWM_EN`): PSC=0, ARR=9, CCR=3 → `pwm_out` high for 3 of every 10 cycles. CCR=0 → constant 0. CCR=12 → constant 1 while in RUN.
